crc_frame_serializer: RTL

Upstream feeder for the serial CRC-8 generator. It accepts a frame of parallel words over a valid/ready/last handshake and shifts them out LSB-first as one contiguous bit stream on DATA, qualified by ACTIVE. After each frame it holds ACTIVE low for a fixed guard gap, so the downstream CRC block can emit its 8 CRC bits before the next frame starts.

---
 rtl/crc_ser_pkg.sv | 21 ++
 rtl/crc_frame_serializer_if.sv | 30 +++
 rtl/crc_frame_serializer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/crc_ser_pkg.sv
// Shared definitions for the CRC frame serializer.
//   ser_state_t     - serializer FSM states (IDLE, SHIFT, GAP)
//   CRC_BITS        - width of the CRC appended downstream
//   DEF_GAP_CYCLES  - default idle gap: room for the CRC bits plus one guard cycle
//   cnt_width()     - counter width able to hold 0..n-1, never less than 1 bit
package crc_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    localparam int CRC_BITS       = 8;
    localparam int DEF_GAP_CYCLES = CRC_BITS + 1;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/crc_frame_serializer_if.sv
// Word-input handshake of the CRC frame serializer.
//   IN_DATA   - parallel word, bit 0 goes out first
//   IN_VALID  - IN_DATA / IN_LAST are valid
//   IN_LAST   - word closes the frame
//   IN_READY  - serializer takes the word at the next rising edge
// Modports: master = word source, slave = serializer.
interface crc_frame_serializer_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] IN_DATA;
    logic                  IN_VALID;
    logic                  IN_LAST;
    logic                  IN_READY;

    modport master (
        output IN_DATA,
        output IN_VALID,
        output IN_LAST,
        input  IN_READY
    );

    modport slave (
        input  IN_DATA,
        input  IN_VALID,
        input  IN_LAST,
        output IN_READY
    );

endinterface

// File: rtl/crc_frame_serializer.sv
// Parallel-to-serial feeder for the serial CRC-8 generator.
// Words arriving on in_if are shifted out LSB-first as one contiguous bit
// stream on DATA, qualified by ACTIVE. After every frame (or truncated frame)
// ACTIVE stays low for GAP_CYCLES cycles in GAP plus the IDLE acceptance
// cycle, which gives the CRC block time to append its check bits.
//
// Ports:
//   CLK          - clock, rising edge
//   RST          - asynchronous, active-low reset
//   in_if        - word handshake (slave modport): IN_DATA/IN_VALID/IN_LAST/IN_READY
//   DATA         - serial bit (registered)
//   ACTIVE       - DATA qualifier (registered)
//   BUSY         - serializer is in SHIFT or GAP
//   UNDERRUN     - one-cycle pulse: frame cut short, next word was missing
//   FRAME_COUNT  - completed frames, wraps at 16 bits
//                  (present only when CRC_SER_FRAME_CNT_EN is defined)
module crc_frame_serializer
    import crc_ser_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                 CLK,
    input  logic                 RST,
    crc_frame_serializer_if.slave in_if,
    output logic                 DATA,
    output logic                 ACTIVE,
    output logic                 BUSY,
    output logic                 UNDERRUN
`ifdef CRC_SER_FRAME_CNT_EN
    ,
    output logic [15:0]          FRAME_COUNT
`endif
);

    localparam int BW = cnt_width(DATA_WIDTH);
    localparam int GW = cnt_width(GAP_CYCLES + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    ser_state_t            state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic [BW-1:0]         bit_cnt, bit_cnt_nxt;
    logic [GW-1:0]         gap_cnt, gap_cnt_nxt;
    logic                  last_flag, last_flag_nxt;
    logic                  data_nxt, active_nxt, underrun_nxt;
    logic                  at_boundary, in_ready, xfer;
`ifdef CRC_SER_FRAME_CNT_EN
    logic [15:0]           frame_cnt_nxt;
`endif

    // The last bit of a word is on DATA; this is the only SHIFT cycle where a
    // follow-on word can be taken without a bubble.
    assign at_boundary    = (state == SHIFT) && (bit_cnt == BIT_LAST);
    assign in_ready       = (state == IDLE) || (at_boundary && !last_flag);
    assign xfer           = in_if.IN_VALID && in_ready;
    assign in_if.IN_READY = in_ready;
    assign BUSY           = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        gap_cnt_nxt   = gap_cnt;
        last_flag_nxt = last_flag;
        data_nxt      = DATA;
        active_nxt    = ACTIVE;
        underrun_nxt  = 1'b0;
`ifdef CRC_SER_FRAME_CNT_EN
        frame_cnt_nxt = FRAME_COUNT;
`endif
        case (state)
            IDLE: begin
                data_nxt   = 1'b0;
                active_nxt = 1'b0;
                if (xfer) begin
                    data_nxt      = in_if.IN_DATA[0];
                    active_nxt    = 1'b1;
                    shreg_nxt     = in_if.IN_DATA >> 1;
                    bit_cnt_nxt   = '0;
                    last_flag_nxt = in_if.IN_LAST;
                    state_nxt     = SHIFT;
                end
            end
            SHIFT: begin
                if (at_boundary) begin
                    if (xfer) begin
                        data_nxt      = in_if.IN_DATA[0];
                        active_nxt    = 1'b1;
                        shreg_nxt     = in_if.IN_DATA >> 1;
                        bit_cnt_nxt   = '0;
                        last_flag_nxt = in_if.IN_LAST;
                    end else begin
                        // Either the frame ended normally or the source
                        // failed to supply the next word in time.
                        data_nxt     = 1'b0;
                        active_nxt   = 1'b0;
                        gap_cnt_nxt  = GAP_LOAD;
                        underrun_nxt = !last_flag;
                        state_nxt    = GAP;
`ifdef CRC_SER_FRAME_CNT_EN
                        if (last_flag) begin
                            frame_cnt_nxt = FRAME_COUNT + 16'd1;
                        end
`endif
                    end
                end else begin
                    data_nxt    = shreg[0];
                    shreg_nxt   = shreg >> 1;
                    bit_cnt_nxt = bit_cnt + BW'(1);
                end
            end
            GAP: begin
                data_nxt   = 1'b0;
                active_nxt = 1'b0;
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - GW'(1);
                end
            end
            default: begin
                data_nxt   = 1'b0;
                active_nxt = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            last_flag   <= 1'b0;
            DATA        <= 1'b0;
            ACTIVE      <= 1'b0;
            UNDERRUN    <= 1'b0;
`ifdef CRC_SER_FRAME_CNT_EN
            FRAME_COUNT <= 16'd0;
`endif
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            last_flag   <= last_flag_nxt;
            DATA        <= data_nxt;
            ACTIVE      <= active_nxt;
            UNDERRUN    <= underrun_nxt;
`ifdef CRC_SER_FRAME_CNT_EN
            FRAME_COUNT <= frame_cnt_nxt;
`endif
        end
    end

endmodule
